ysyx_20020207_alu_arbiter: RTL and testbench

YSYX_20020207_ALU_ARBITER -- requirements
Module: ysyx_20020207_alu_arbiter

---
 rtl/ysyx_20020207_alu_arbiter_pkg.sv | 51 +++++
 rtl/ysyx_20020207_rr_arb2.sv | 53 +++++
 rtl/ysyx_20020207_alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ysyx_20020207_alu_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_20020207_alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// requester IDs, ALU opcode values and the latched operation record.
package ysyx_20020207_alu_arbiter_pkg;

   localparam int NUM_REQ = 2;
   localparam int XLEN    = 32;

   // Arbiter control states; exactly one ALU operation is in flight at a time.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Requester identifiers (bit position in req_valid / resp_valid).
   localparam logic REQ_EXU = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   // 4-bit ALU opcodes understood by the downstream ALU.
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLL  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_BEQ  = 4'd8;
   localparam logic [3:0] ALU_BNE  = 4'd9;
   localparam logic [3:0] ALU_BLT  = 4'd10;
   localparam logic [3:0] ALU_BGE  = 4'd11;
   localparam logic [3:0] ALU_BLTU = 4'd12;
   localparam logic [3:0] ALU_BGEU = 4'd13;

   // Operation latched from the granted requester and driven onto the ALU.
   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [3:0]      ctrl;
      logic            sub;
      logic            sign;
      logic            lr;
   } alu_op_t;

   // Requester ID to its one-hot position on the 2-bit handshake vectors.
   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ysyx_20020207_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins a
// tie; after every accepted grant it moves to the requester not granted.
module ysyx_20020207_rr_arb2
   import ysyx_20020207_alu_arbiter_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       en_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o
);

   logic ptr_q;
   logic ptr_d;
   logic alt;

   assign alt = ~ptr_q;

   // Pick the pointer-preferred requester first, otherwise the other one.
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = ptr_q;
      if (en_i) begin
         if (req_i[ptr_q]) begin
            gnt_o    = id_to_onehot(ptr_q);
            gnt_id_o = ptr_q;
         end else if (req_i[alt]) begin
            gnt_o    = id_to_onehot(alt);
            gnt_id_o = alt;
         end
      end
   end

   // Pointer moves away from whoever was just served.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = ~gnt_id_o;
      end
   end

   // Pointer register, restarts at the EXU requester.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= REQ_EXU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ysyx_20020207_alu_arbiter.sv
// Shares one ALU between the EXU and an auxiliary unit. One operation is in
// flight at a time: grant, launch for a single cycle, wait for the ALU (with a
// timeout), then hold the response for its owner until it is accepted.
// TIMEOUT is expected to be at least 2.
module ysyx_20020207_alu_arbiter
   import ysyx_20020207_alu_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 8
)(
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0][31:0] req_a,
   input  logic [1:0][31:0] req_b,
   input  logic [1:0][3:0] req_ctrl,
   input  logic [1:0]      req_sub,
   input  logic [1:0]      req_sign,
   input  logic [1:0]      req_lr,
   output logic [1:0]      resp_valid,
   input  logic [1:0]      resp_ready,
   output logic [31:0]     resp_result,
   output logic [31:0]     resp_addr,
   output logic            resp_branch,
   output logic            resp_err,
   output logic            ctrl_valid,
   output logic            lr,
   output logic            alu_sub,
   output logic            alu_sign,
   output logic [31:0]     alu_a,
   output logic [31:0]     alu_b,
   output logic [3:0]      alu_ctrl,
   input  logic [31:0]     result,
   input  logic [31:0]     lsu_addr,
   input  logic            branch,
   input  logic            addr_valid,
   input  logic            alu_valid
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e       state_q, state_d;
   alu_op_t          op_q, op_d;
   logic             owner_q, owner_d;
   logic [31:0]      res_q, res_d;
   logic [31:0]      addr_q, addr_d;
   logic             br_q, br_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       gnt;
   logic             gnt_id;
   logic             arb_en;
   logic             accept;

   // Grants are only offered while idle and never while reset is applied.
   assign arb_en = (state_q == ST_IDLE) && !reset;

   ysyx_20020207_rr_arb2 u_rr_arb2 (
      .clock    (clock),
      .reset    (reset),
      .req_i    (req_valid),
      .en_i     (arb_en),
      .accept_i (accept),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   assign req_ready = gnt;
   assign accept    = |(req_valid & gnt);

   // Next-state and datapath capture for the issue/wait/respond sequence.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      owner_d = owner_q;
      res_d   = res_q;
      addr_d  = addr_q;
      br_d    = br_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d.a    = req_a[gnt_id];
               op_d.b    = req_b[gnt_id];
               op_d.ctrl = req_ctrl[gnt_id];
               op_d.sub  = req_sub[gnt_id];
               op_d.sign = req_sign[gnt_id];
               op_d.lr   = req_lr[gnt_id];
               owner_d   = gnt_id;
               res_d     = '0;
               addr_d    = '0;
               br_d      = 1'b0;
               err_d     = 1'b0;
               cnt_d     = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // The launch cycle itself counts as the first elapsed cycle.
            cnt_d   = CNT_W'(1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (addr_valid) begin
               addr_d = lsu_addr;
            end
            if (alu_valid) begin
               res_d   = result;
               br_d    = branch;
               state_d = ST_RESP;
            end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
               // Give up: the response reports an error and carries no data.
               res_d   = '0;
               addr_d  = '0;
               br_d    = 1'b0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready[owner_q]) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operation and response registers; reset drops any in-flight op.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         owner_q <= REQ_EXU;
         res_q   <= '0;
         addr_q  <= '0;
         br_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         owner_q <= owner_d;
         res_q   <= res_d;
         addr_q  <= addr_d;
         br_q    <= br_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ctrl_valid  = (state_q == ST_ISSUE);
   assign alu_a       = op_q.a;
   assign alu_b       = op_q.b;
   assign alu_ctrl    = op_q.ctrl;
   assign alu_sub     = op_q.sub;
   assign alu_sign    = op_q.sign;
   assign lr          = op_q.lr;

   assign resp_valid  = (state_q == ST_RESP) ? id_to_onehot(owner_q) : 2'b00;
   assign resp_result = res_q;
   assign resp_addr   = addr_q;
   assign resp_branch = br_q;
   assign resp_err    = err_q;

endmodule

// File: tb/tb_ysyx_20020207_alu_arbiter.sv
// Bench for the ALU arbiter: a bench-side ALU, a transaction-level model
// compared every cycle, and directed scenarios with literal expectations.
module tb_ysyx_20020207_alu_arbiter;

   localparam int TIMEOUT = 8;

   logic             clock;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   logic [1:0][3:0]  req_ctrl;
   logic [1:0]       req_sub;
   logic [1:0]       req_sign;
   logic [1:0]       req_lr;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [31:0]      resp_result;
   logic [31:0]      resp_addr;
   logic             resp_branch;
   logic             resp_err;
   logic             ctrl_valid;
   logic             lr;
   logic             alu_sub;
   logic             alu_sign;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [3:0]       alu_ctrl;
   logic [31:0]      result;
   logic [31:0]      lsu_addr;
   logic             branch;
   logic             addr_valid;
   logic             alu_valid;

   int n_checks = 0;
   int n_fail   = 0;

   bit alu_mode     = 1'b0;   // 0: conforming ALU, 1: ALU never answers
   bit inject_stray = 1'b0;   // request one unsolicited alu_valid pulse

   ysyx_20020207_alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ctrl    (req_ctrl),
      .req_sub     (req_sub),
      .req_sign    (req_sign),
      .req_lr      (req_lr),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_addr   (resp_addr),
      .resp_branch (resp_branch),
      .resp_err    (resp_err),
      .ctrl_valid  (ctrl_valid),
      .lr          (lr),
      .alu_sub     (alu_sub),
      .alu_sign    (alu_sign),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ctrl    (alu_ctrl),
      .result      (result),
      .lsu_addr    (lsu_addr),
      .branch      (branch),
      .addr_valid  (addr_valid),
      .alu_valid   (alu_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_res(input logic s, input logic [31:0] a, input logic [31:0] b);
      return s ? a - b : a + b;
   endfunction

   function automatic logic alu_br(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      return (c == 4'd8) && (a == b);
   endfunction

   // Bench ALU: addr_valid one cycle and alu_valid two cycles after a launch.
   logic        seen, s1, b1, sb_br, stray;
   logic [31:0] sa, sb, r1;
   logic [3:0]  sc;
   logic        ss;
   initial begin
      addr_valid = 1'b0;
      alu_valid  = 1'b0;
      result     = '0;
      lsu_addr   = '0;
      branch     = 1'b0;
      s1 = 1'b0; r1 = '0; b1 = 1'b0; sb_br = 1'b0;
      forever begin
         @(negedge clock);
         seen  = (ctrl_valid === 1'b1) && (alu_mode == 1'b0);
         sa    = alu_a;
         sb    = alu_b;
         sc    = alu_ctrl;
         ss    = alu_sub;
         stray = inject_stray;
         @(posedge clock);
         #1;
         addr_valid = seen;
         lsu_addr   = seen ? sa + sb : 32'h0;
         alu_valid  = s1 | stray;
         result     = s1 ? r1 : (stray ? 32'hDEAD_BEEF : 32'h0);
         branch     = s1 ? b1 : stray;
         s1 = seen;
         r1 = alu_res(ss, sa, sb);
         b1 = alu_br(sc, sa, sb);
      end
   end

   // Transaction-level model of the arbiter.
   int          cyc = 0;
   bit          m_busy, m_owner, m_ptr, m_err, m_to;
   int          m_acc, m_resp;
   logic [31:0] m_a, m_b, e_res, e_addr;
   logic [3:0]  m_ctrl;
   logic        m_sub, m_sign, m_lr, e_br;
   logic [1:0]  e_ready;

   task automatic model_compare();
      bit in_resp;
      int idx;
      e_ready = 2'b00;
      if (!reset && !m_busy) begin
         for (int k = 0; k < 2; k++) begin
            idx = (int'(m_ptr) + k) % 2;
            if (e_ready == 2'b00 && req_valid[idx]) e_ready = (idx == 0) ? 2'b01 : 2'b10;
         end
      end
      in_resp = m_busy && (cyc >= m_resp);
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(m_busy && (cyc == m_acc + 1)));
      chk("resp_valid", 32'(resp_valid), in_resp ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      chk("resp_err", 32'(resp_err), 32'(m_err));
      if (in_resp) begin
         chk("resp_result", resp_result, e_res);
         chk("resp_addr", resp_addr, e_addr);
         chk("resp_branch", 32'(resp_branch), 32'(e_br));
      end
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      chk("alu_flags", {29'd0, alu_sub, alu_sign, lr}, {29'd0, m_sub, m_sign, m_lr});
   endtask

   task automatic model_update();
      int id;
      if (reset) begin
         m_busy = 1'b0; m_ptr = 1'b0; m_err = 1'b0;
         m_a = '0; m_b = '0; m_ctrl = '0; m_sub = 1'b0; m_sign = 1'b0; m_lr = 1'b0;
      end else begin
         if (m_busy && (cyc + 1 == m_resp)) m_err = m_to;
         if (m_busy && (cyc >= m_resp) && resp_ready[m_owner]) begin
            m_busy = 1'b0;
         end else if (!m_busy && ((req_valid & e_ready) != 2'b00)) begin
            id      = e_ready[1] ? 1 : 0;
            m_owner = e_ready[1];
            m_ptr   = !e_ready[1];
            m_a     = req_a[id];
            m_b     = req_b[id];
            m_ctrl  = req_ctrl[id];
            m_sub   = req_sub[id];
            m_sign  = req_sign[id];
            m_lr    = req_lr[id];
            m_busy  = 1'b1;
            m_acc   = cyc;
            m_to    = alu_mode;
            m_resp  = cyc + (m_to ? 1 + TIMEOUT : 4);
            m_err   = 1'b0;
            e_res   = m_to ? 32'h0 : alu_res(m_sub, m_a, m_b);
            e_addr  = m_to ? 32'h0 : m_a + m_b;
            e_br    = m_to ? 1'b0 : alu_br(m_ctrl, m_a, m_b);
         end
      end
      cyc++;
   endtask

   initial begin
      @(posedge clock);
      model_update();
      forever begin
         @(negedge clock);
         model_compare();
         @(posedge clock);
         model_update();
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic s, input logic sg, input logic l);
      req_a[id] = a; req_b[id] = b; req_ctrl[id] = c;
      req_sub[id] = s; req_sign[id] = sg; req_lr[id] = l;
   endtask

   int grants[16];
   int ng;

   initial begin
      reset = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;
      req_sub = '0; req_sign = '0; req_lr = '0; resp_ready = '0;

      // Reset state, including no grant while reset is held.
      step();
      req_valid = 2'b01;
      mid();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_result", resp_result, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      step();
      req_valid = 2'b00;
      reset = 1'b0;
      step();

      // EXU add 5 + 7.
      set_req(0, 32'd5, 32'd7, 4'd0, 1'b0, 1'b1, 1'b0);
      req_valid = 2'b01;
      mid();
      chk("t1_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      mid();
      chk("t1_ctrl_valid", 32'(ctrl_valid), 32'd1);
      chk("t1_alu_a", alu_a, 32'd5);
      chk("t1_alu_b", alu_b, 32'd7);
      step(); step();
      mid();
      chk("t1_resp_early", 32'(resp_valid), 32'd0);
      step();
      resp_ready = 2'b01;
      mid();
      chk("t1_resp_valid", 32'(resp_valid), 32'd1);
      chk("t1_result", resp_result, 32'd12);
      chk("t1_addr", resp_addr, 32'd12);
      step();
      resp_ready = 2'b00;
      mid();
      chk("t1_resp_done", 32'(resp_valid), 32'd0);

      // Both requesters held: grants alternate starting at requester 0.
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_req(0, 32'd1, 32'd2, 4'd0, 1'b0, 1'b0, 1'b1);
      set_req(1, 32'd100, 32'd23, 4'd0, 1'b1, 1'b1, 1'b0);
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      ng = 0;
      for (int i = 0; i < 26; i++) begin
         mid();
         if (req_ready != 2'b00 && ng < 16) begin
            grants[ng] = req_ready[1] ? 1 : 0;
            ng++;
         end
         step();
      end
      req_valid = 2'b00;
      for (int i = 0; i < 6; i++) step();
      resp_ready = 2'b00;
      chk("t2_grant_count", 32'(ng >= 4), 32'd1);
      chk("t2_grant0", 32'(grants[0]), 32'd0);
      chk("t2_grant1", 32'(grants[1]), 32'd1);
      chk("t2_grant2", 32'(grants[2]), 32'd0);
      chk("t2_grant3", 32'(grants[3]), 32'd1);

      // Aux BEQ 3 == 3 with a stalled consumer and an EXU request waiting.
      set_req(1, 32'd3, 32'd3, 4'd8, 1'b1, 1'b0, 1'b1);
      req_valid = 2'b10;
      mid();
      chk("t3_req_ready", 32'(req_ready), 32'd2);
      step();
      set_req(0, 32'd20, 32'd22, 4'd0, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b01;
      mid();
      chk("t3_ctrl_valid", 32'(ctrl_valid), 32'd1);
      chk("t3_no_grant_busy", 32'(req_ready), 32'd0);
      step(); step(); step();
      mid();
      chk("t3_resp_valid", 32'(resp_valid), 32'd2);
      chk("t3_branch", 32'(resp_branch), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         mid();
         chk("t3_hold_valid", 32'(resp_valid), 32'd2);
         chk("t3_hold_branch", 32'(resp_branch), 32'd1);
         chk("t3_hold_result", resp_result, 32'd0);
         chk("t3_hold_addr", resp_addr, 32'd6);
         chk("t3_hold_no_grant", 32'(req_ready), 32'd0);
      end
      step();
      resp_ready = 2'b10;
      mid();
      chk("t3_release_cycle", 32'(req_ready), 32'd0);
      step();
      resp_ready = 2'b00;
      mid();
      chk("t3_exu_granted", 32'(req_ready), 32'd1);
      step();
      req_valid  = 2'b00;
      resp_ready = 2'b01;
      for (int i = 0; i < 6; i++) step();
      resp_ready = 2'b00;

      // Silent ALU: timeout exactly TIMEOUT cycles after the launch.
      alu_mode = 1'b1;
      set_req(0, 32'd9, 32'd9, 4'd0, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b01;
      mid();
      chk("t4_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      mid();
      chk("t4_ctrl_valid", 32'(ctrl_valid), 32'd1);
      for (int k = 1; k < TIMEOUT; k++) begin
         step();
         mid();
         chk("t4_wait_no_resp", 32'(resp_valid), 32'd0);
         chk("t4_wait_no_err", 32'(resp_err), 32'd0);
      end
      step();
      resp_ready   = 2'b01;
      inject_stray = 1'b1;
      mid();
      chk("t4_err", 32'(resp_err), 32'd1);
      chk("t4_resp_valid", 32'(resp_valid), 32'd1);
      chk("t4_result_zero", resp_result, 32'd0);
      chk("t4_addr_zero", resp_addr, 32'd0);
      step();
      resp_ready   = 2'b00;
      inject_stray = 1'b0;
      mid();
      chk("t4_late_ignored", 32'(resp_valid), 32'd0);
      chk("t4_err_sticky", 32'(resp_err), 32'd1);
      step();
      alu_mode = 1'b0;
      set_req(0, 32'd2, 32'd3, 4'd0, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b01;
      mid();
      chk("t4_err_before_accept", 32'(resp_err), 32'd1);
      step();
      req_valid = 2'b00;
      mid();
      chk("t4_err_cleared", 32'(resp_err), 32'd0);
      resp_ready = 2'b01;
      for (int i = 0; i < 5; i++) step();
      resp_ready = 2'b00;

      // Reset while waiting on the ALU; the late return must be ignored.
      set_req(0, 32'd4, 32'd4, 4'd8, 1'b1, 1'b1, 1'b1);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      mid();
      chk("t5_ctrl_valid", 32'(ctrl_valid), 32'd0);
      chk("t5_resp_valid", 32'(resp_valid), 32'd0);
      chk("t5_resp_err", 32'(resp_err), 32'd0);
      chk("t5_resp_result", resp_result, 32'd0);
      chk("t5_resp_addr", resp_addr, 32'd0);
      chk("t5_resp_branch", 32'(resp_branch), 32'd0);
      chk("t5_alu_a", alu_a, 32'd0);
      chk("t5_alu_b", alu_b, 32'd0);
      chk("t5_alu_ctrl", 32'(alu_ctrl), 32'd0);
      chk("t5_alu_flags", {29'd0, alu_sub, alu_sign, lr}, 32'd0);
      inject_stray = 1'b1;
      step();
      inject_stray = 1'b0;
      resp_ready = 2'b11;
      for (int i = 0; i < 5; i++) begin
         step();
         mid();
         chk("t5_no_stray_resp", 32'(resp_valid), 32'd0);
      end
      resp_ready = 2'b00;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
